// File: rtl/eth_pkg.sv
// Shared definitions for the UDP user-side loopback buffer.
// Provides the FSM state encoding, byte and counter widths, the default
// payload buffer depth and a saturating counter helper.
package eth_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned DEFAULT_DEPTH = 2048;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RX   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_TX   = 2'd3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/udp_loopback_buf_if.sv
// UDP user interface between the eth protocol block and a user-side client.
// master : eth block (delivers received payload, requests transmit bytes)
// slave  : user client (stores payload, starts transmit, serves bytes)
// Signals:
//   udp_rx_data_vld / udp_rx_data / udp_rx_done / udp_rx_data_num : receive path
//   tx_rdy / udp_tx_req                                            : transmit status
//   udp_tx_en / udp_tx_data_num / udp_tx_data                      : transmit path
interface udp_loopback_buf_if;
    import eth_pkg::*;

    logic              udp_rx_data_vld;
    logic [BYTE_W-1:0] udp_rx_data;
    logic              udp_rx_done;
    logic [CNT_W-1:0]  udp_rx_data_num;
    logic              tx_rdy;
    logic              udp_tx_req;
    logic              udp_tx_en;
    logic [CNT_W-1:0]  udp_tx_data_num;
    logic [BYTE_W-1:0] udp_tx_data;

    modport master (
        output udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
        output tx_rdy, udp_tx_req,
        input  udp_tx_en, udp_tx_data_num, udp_tx_data
    );

    modport slave (
        input  udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
        input  tx_rdy, udp_tx_req,
        output udp_tx_en, udp_tx_data_num, udp_tx_data
    );

endinterface

// File: rtl/udp_frame_ram.sv
// Simple dual-port payload RAM: one write port, one read port, DEPTH x 8,
// read data registered one cycle after rd_en and held otherwise.
// Ports:
//   clk              : clock shared by both ports
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : read request
//   rd_data          : registered read data
module udp_frame_ram
    import eth_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [BYTE_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [BYTE_W-1:0]         rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_loopback_buf.sv
// Single-frame UDP echo buffer on the eth block's UDP user interface.
// Captures one received payload into RAM, starts a transmission once the
// transmitter is ready and serves the payload back byte by byte on request.
// Frames arriving while a frame is held are dropped and counted.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   udp         : UDP user interface (slave side)
//   busy        : high whenever the FSM is not idle
//   drop_cnt    : saturating count of dropped frames
//   len_err_cnt : saturating count of frames whose byte count != reported length
module udp_loopback_buf
    import eth_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udp_loopback_buf_if.slave    udp,
    output logic                 busy,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [CNT_W-1:0]     len_err_cnt
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CTR_W  = ADDR_W + 1;
    localparam logic [CTR_W-1:0] DEPTH_C = CTR_W'(DEPTH);

    logic [1:0]        state_q,   state_nxt;
    logic [CTR_W-1:0]  wr_cnt_q,  wr_cnt_nxt;
    logic [CTR_W-1:0]  rd_cnt_q,  rd_cnt_nxt;
    logic [CTR_W-1:0]  len_q,     len_nxt;
    logic [CNT_W-1:0]  tx_num_q,  tx_num_nxt;
    logic              tx_en_q,   tx_en_nxt;
    logic              zero_q,    zero_nxt;
    logic              busy_q,    busy_nxt;
    logic [CNT_W-1:0]  drop_q,    drop_nxt;
    logic [CNT_W-1:0]  lerr_q,    lerr_nxt;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [BYTE_W-1:0] ram_rdata;

    logic              rx_take;
    logic [CTR_W-1:0]  rx_base;
    logic [CTR_W-1:0]  rx_len;
    logic              rd_accept;

    udp_frame_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (udp.udp_rx_data),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            len_q    <= '0;
            tx_num_q <= '0;
            tx_en_q  <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            drop_q   <= '0;
            lerr_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            wr_cnt_q <= wr_cnt_nxt;
            rd_cnt_q <= rd_cnt_nxt;
            len_q    <= len_nxt;
            tx_num_q <= tx_num_nxt;
            tx_en_q  <= tx_en_nxt;
            zero_q   <= zero_nxt;
            busy_q   <= busy_nxt;
            drop_q   <= drop_nxt;
            lerr_q   <= lerr_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt  = state_q;
        wr_cnt_nxt = wr_cnt_q;
        rd_cnt_nxt = rd_cnt_q;
        len_nxt    = len_q;
        tx_num_nxt = tx_num_q;
        tx_en_nxt  = 1'b0;
        zero_nxt   = zero_q;
        drop_nxt   = drop_q;
        lerr_nxt   = lerr_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_re     = 1'b0;
        ram_raddr  = rd_cnt_q[ADDR_W-1:0];
        rx_take    = 1'b0;
        rx_base    = '0;
        rx_len     = '0;
        rd_accept  = 1'b0;

        case (state_q)
            ST_IDLE, ST_RX: begin
                // A new frame always starts at address 0; bytes past DEPTH are discarded.
                rx_base = (state_q == ST_IDLE) ? '0 : wr_cnt_q;
                rx_take = udp.udp_rx_data_vld && (rx_base < DEPTH_C);
                rx_len  = rx_base + CTR_W'(rx_take);
                if (rx_take) begin
                    ram_we     = 1'b1;
                    ram_waddr  = rx_base[ADDR_W-1:0];
                    wr_cnt_nxt = rx_len;
                    state_nxt  = ST_RX;
                end
                // Counted length wins over the reported one; empty frames are ignored.
                if (udp.udp_rx_done) begin
                    if (rx_len != '0) begin
                        if (CNT_W'(rx_len) != udp.udp_rx_data_num) begin
                            lerr_nxt = sat_inc(lerr_q);
                        end
                        len_nxt   = rx_len;
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_WAIT: begin
                if (udp.udp_rx_done) begin
                    drop_nxt = sat_inc(drop_q);
                end
                if (udp.tx_rdy) begin
                    tx_en_nxt  = 1'b1;
                    tx_num_nxt = CNT_W'(len_q);
                    rd_cnt_nxt = '0;
                    state_nxt  = ST_TX;
                end
            end

            ST_TX: begin
                if (udp.udp_rx_done) begin
                    drop_nxt = sat_inc(drop_q);
                end
                if (udp.udp_tx_req && (rd_cnt_q < len_q)) begin
                    rd_accept  = 1'b1;
                    ram_re     = 1'b1;
                    rd_cnt_nxt = rd_cnt_q + CTR_W'(1);
                    if (rd_cnt_q == len_q - CTR_W'(1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Any request that is not served yields a zero byte next cycle.
        if (rd_accept) begin
            zero_nxt = 1'b0;
        end else if (udp.udp_tx_req) begin
            zero_nxt = 1'b1;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign udp.udp_tx_en       = tx_en_q;
    assign udp.udp_tx_data_num = tx_num_q;
    // Byte is the registered RAM output, forced to zero after reset or an unserved request.
    assign udp.udp_tx_data     = zero_q ? '0 : ram_rdata;
    assign busy                = busy_q;
    assign drop_cnt            = drop_q;
    assign len_err_cnt         = lerr_q;

endmodule
